// File: rtl/frame_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// frame_scheduler_pkg
// Shared definitions for the per-frame coprocessor sequencer: FSM state
// encoding (visible to software through STATUS[4:2]), MMIO register indices
// and the default select value of this block in the MMIO map.
// -----------------------------------------------------------------------------
package frame_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PHYS = 3'd1,
      ST_COLL = 3'd2,
      ST_ATK  = 3'd3,
      ST_DMG  = 3'd4,
      ST_VGA  = 3'd5
   } state_e;

   localparam logic [4:0] IDX_CTRL        = 5'd0;
   localparam logic [4:0] IDX_LEN_PHYS    = 5'd1;
   localparam logic [4:0] IDX_LEN_COLL    = 5'd2;
   localparam logic [4:0] IDX_LEN_ATK     = 5'd3;
   localparam logic [4:0] IDX_LEN_DMG     = 5'd4;
   localparam logic [4:0] IDX_LEN_VGA     = 5'd5;
   localparam logic [4:0] IDX_FRAME_COUNT = 5'd6;
   localparam logic [4:0] IDX_STATUS      = 5'd7;

   localparam logic [4:0] BASE_SEL_DEFAULT = 5'd14;

endpackage

// File: rtl/frame_sched_regs.sv
// -----------------------------------------------------------------------------
// frame_sched_regs
// MMIO decode, configuration registers and combinational read mux for the
// frame scheduler.
//
// Ports:
//   clock, reset          system clock, async active-high reset
//   address, data_in, wren processor MMIO bus
//   state_i, busy_i,       live scheduler status for STATUS / FRAME_COUNT reads
//   overrun_i, frame_count_i
//   run_o                  CTRL.run
//   clr_ovr_o              one-cycle pulse: CTRL written with bit1 set
//   len_*_o                raw phase-length registers (0 is legal, means 1)
//   rdata_o                read data for the addressed register, 0 on miss
// -----------------------------------------------------------------------------
module frame_sched_regs
   import frame_scheduler_pkg::*;
#(
   parameter int         LEN_W       = 8,
   parameter int         DEFAULT_LEN = 4,
   parameter logic [4:0] BASE_SEL    = BASE_SEL_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [12:0]      address,
   input  logic [31:0]      data_in,
   input  logic             wren,
   input  logic [2:0]       state_i,
   input  logic             busy_i,
   input  logic             overrun_i,
   input  logic [31:0]      frame_count_i,
   output logic             run_o,
   output logic             clr_ovr_o,
   output logic [LEN_W-1:0] len_phys_o,
   output logic [LEN_W-1:0] len_coll_o,
   output logic [LEN_W-1:0] len_atk_o,
   output logic [LEN_W-1:0] len_dmg_o,
   output logic [LEN_W-1:0] len_vga_o,
   output logic [31:0]      rdata_o
);

   logic             hit;
   logic [4:0]       idx;
   logic             we;
   logic             run_q;
   logic [LEN_W-1:0] len_phys_q, len_coll_q, len_atk_q, len_dmg_q, len_vga_q;
   logic             unused_bits;

   assign hit = address[12] && (address[11:7] == BASE_SEL);
   assign idx = address[6:2];
   assign we  = hit && wren;

   // Upper data bits and byte offset carry no meaning for this block.
   assign unused_bits = ^{data_in[31:LEN_W], address[1:0]};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         run_q      <= 1'b0;
         len_phys_q <= LEN_W'(DEFAULT_LEN);
         len_coll_q <= LEN_W'(DEFAULT_LEN);
         len_atk_q  <= LEN_W'(DEFAULT_LEN);
         len_dmg_q  <= LEN_W'(DEFAULT_LEN);
         len_vga_q  <= LEN_W'(DEFAULT_LEN);
      end else if (we) begin
         case (idx)
            IDX_CTRL:     run_q      <= data_in[0];
            IDX_LEN_PHYS: len_phys_q <= data_in[LEN_W-1:0];
            IDX_LEN_COLL: len_coll_q <= data_in[LEN_W-1:0];
            IDX_LEN_ATK:  len_atk_q  <= data_in[LEN_W-1:0];
            IDX_LEN_DMG:  len_dmg_q  <= data_in[LEN_W-1:0];
            IDX_LEN_VGA:  len_vga_q  <= data_in[LEN_W-1:0];
            default:      ;
         endcase
      end
   end

   assign clr_ovr_o = we && (idx == IDX_CTRL) && data_in[1];

   always_comb begin
      rdata_o = 32'd0;
      if (hit) begin
         case (idx)
            IDX_CTRL:        rdata_o = {31'd0, run_q};
            IDX_LEN_PHYS:    rdata_o = 32'(len_phys_q);
            IDX_LEN_COLL:    rdata_o = 32'(len_coll_q);
            IDX_LEN_ATK:     rdata_o = 32'(len_atk_q);
            IDX_LEN_DMG:     rdata_o = 32'(len_dmg_q);
            IDX_LEN_VGA:     rdata_o = 32'(len_vga_q);
            IDX_FRAME_COUNT: rdata_o = frame_count_i;
            IDX_STATUS:      rdata_o = {26'd0, busy_i, state_i, overrun_i, run_q};
            default:         rdata_o = 32'd0;
         endcase
      end
   end

   assign run_o      = run_q;
   assign len_phys_o = len_phys_q;
   assign len_coll_o = len_coll_q;
   assign len_atk_o  = len_atk_q;
   assign len_dmg_o  = len_dmg_q;
   assign len_vga_o  = len_vga_q;

endmodule

// File: rtl/frame_scheduler.sv
// -----------------------------------------------------------------------------
// frame_scheduler
// Per-frame sequencer: on a frame tick (while run is set) opens one-hot
// enable windows for physics, collision, attack, damage and VGA snapshot in
// that order, each for its programmed length. Ticks arriving mid-frame are
// dropped and flagged as overrun.
//
// Ports:
//   clock, reset            system clock, async active-high reset
//   frame_tick              single-cycle frame start pulse
//   address, data_in, wren  processor MMIO bus
//   rdata                   combinational read data
//   en_phys..en_vga         mutually exclusive stage enable windows
//   busy                    FSM not in IDLE
//   overrun                 sticky, cleared by writing CTRL bit1
//   frame_count             completed frames (wraps)
//
// state | meaning
// IDLE  | waiting for frame_tick with run set
// PHYS  | physics window open
// COLL  | collision window open
// ATK   | attack window open
// DMG   | damage window open
// VGA   | VGA snapshot window open; last cycle completes the frame
// -----------------------------------------------------------------------------
module frame_scheduler
   import frame_scheduler_pkg::*;
#(
   parameter int         LEN_W       = 8,
   parameter int         DEFAULT_LEN = 4,
   parameter logic [4:0] BASE_SEL    = BASE_SEL_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic [12:0] address,
   input  logic [31:0] data_in,
   input  logic        wren,
   output logic [31:0] rdata,
   output logic        en_phys,
   output logic        en_coll,
   output logic        en_attack,
   output logic        en_damage,
   output logic        en_vga,
   output logic        busy,
   output logic        overrun,
   output logic [31:0] frame_count
);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [31:0]      frame_count_q, frame_count_d;
   logic             overrun_q, overrun_d;

   logic             run;
   logic             clr_ovr;
   logic [LEN_W-1:0] len_phys, len_coll, len_atk, len_dmg, len_vga;

   frame_sched_regs #(
      .LEN_W       (LEN_W),
      .DEFAULT_LEN (DEFAULT_LEN),
      .BASE_SEL    (BASE_SEL)
   ) u_regs (
      .clock         (clock),
      .reset         (reset),
      .address       (address),
      .data_in       (data_in),
      .wren          (wren),
      .state_i       (state_q),
      .busy_i        (busy),
      .overrun_i     (overrun_q),
      .frame_count_i (frame_count_q),
      .run_o         (run),
      .clr_ovr_o     (clr_ovr),
      .len_phys_o    (len_phys),
      .len_coll_o    (len_coll),
      .len_atk_o     (len_atk),
      .len_dmg_o     (len_dmg),
      .len_vga_o     (len_vga),
      .rdata_o       (rdata)
   );

   // Counter start value for a phase of length len; a length of 0 runs as 1.
   function automatic logic [LEN_W-1:0] load_of(input logic [LEN_W-1:0] len);
      return (len == '0) ? '0 : len - LEN_W'(1);
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         frame_count_q <= 32'd0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         frame_count_q <= frame_count_d;
         overrun_q     <= overrun_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      frame_count_d = frame_count_q;

      case (state_q)
         ST_IDLE: begin
            if (run && frame_tick) begin
               state_d = ST_PHYS;
               cnt_d   = load_of(len_phys);
            end
         end
         ST_PHYS: begin
            if (cnt_q == '0) begin
               state_d = ST_COLL;
               cnt_d   = load_of(len_coll);
            end else begin
               cnt_d = cnt_q - LEN_W'(1);
            end
         end
         ST_COLL: begin
            if (cnt_q == '0) begin
               state_d = ST_ATK;
               cnt_d   = load_of(len_atk);
            end else begin
               cnt_d = cnt_q - LEN_W'(1);
            end
         end
         ST_ATK: begin
            if (cnt_q == '0) begin
               state_d = ST_DMG;
               cnt_d   = load_of(len_dmg);
            end else begin
               cnt_d = cnt_q - LEN_W'(1);
            end
         end
         ST_DMG: begin
            if (cnt_q == '0) begin
               state_d = ST_VGA;
               cnt_d   = load_of(len_vga);
            end else begin
               cnt_d = cnt_q - LEN_W'(1);
            end
         end
         ST_VGA: begin
            if (cnt_q == '0) begin
               state_d       = ST_IDLE;
               cnt_d         = '0;
               frame_count_d = frame_count_q + 32'd1;
            end else begin
               cnt_d = cnt_q - LEN_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Set is applied after clear so a dropped tick is never lost to a
   // simultaneous software clear.
   always_comb begin
      overrun_d = overrun_q;
      if (clr_ovr) begin
         overrun_d = 1'b0;
      end
      if (frame_tick && (state_q != ST_IDLE)) begin
         overrun_d = 1'b1;
      end
   end

   assign en_phys     = (state_q == ST_PHYS);
   assign en_coll     = (state_q == ST_COLL);
   assign en_attack   = (state_q == ST_ATK);
   assign en_damage   = (state_q == ST_DMG);
   assign en_vga      = (state_q == ST_VGA);
   assign busy        = (state_q != ST_IDLE);
   assign overrun     = overrun_q;
   assign frame_count = frame_count_q;

endmodule
